// File: rtl/lsu_pkg.sv
// Shared LSU types: memory op encoding and the request record that travels
// down the responder pipeline. Widths here are the core-wide LSU widths; the
// responder's XLEN/ROB_TAG_WIDTH parameters are expected to match them.
package lsu_pkg;

  localparam int LSU_XLEN          = 32;
  localparam int LSU_ROB_TAG_WIDTH = 32;
  // Widest possible word index for a byte address of LSU_XLEN bits.
  localparam int LSU_INDEX_WIDTH   = LSU_XLEN - 2;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_t;

  typedef struct packed {
    logic                         valid;
    mem_op_t                      op;
    logic [LSU_INDEX_WIDTH-1:0]   index;
    logic [LSU_XLEN-1:0]          data;
    logic [LSU_ROB_TAG_WIDTH-1:0] rob_tag;
  } mem_req_t;

  // Drop a load when a flush is applied; stores are committed and survive.
  function automatic mem_req_t flush_filter(mem_req_t req, logic flush);
    mem_req_t r;
    r = req;
    if (flush && (req.op == MEM_LOAD)) r.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mem_req_pipe.sv
// Fixed-latency request pipeline: LATENCY stages of mem_req_t shifted every
// cycle. A flush clears the valid bit of every load moving between stages,
// including the one entering stage 0.
module mem_req_pipe
  import lsu_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  mem_req_t in_req,
  output mem_req_t out_req
);

  mem_req_t stage_q [LATENCY];

  // Shift the request records one stage per cycle, squashing loads on flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignment makes every stage take its
      // predecessor's old value, so the loop order does not matter.
      stage_q[0] <= flush_filter(in_req, flush);
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i] <= flush_filter(stage_q[i-1], flush);
      end
    end
  end

  assign out_req = stage_q[LATENCY-1];

endmodule

// File: rtl/data_memory_responder.sv
// LSU memory responder: accepts one request per cycle, carries it through a
// fixed-latency pipeline and services it against a word-addressed array in
// the final stage. Loads read combinationally; stores write at the end of
// their final-stage cycle, so in-order issue gives store-to-load ordering.
module data_memory_responder
  import lsu_pkg::*;
#(
  parameter int XLEN          = LSU_XLEN,
  parameter int ROB_TAG_WIDTH = LSU_ROB_TAG_WIDTH,
  parameter int DEPTH         = 1024,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fire_memory_op,
  input  logic                     memory_op_type,
  input  logic [XLEN-1:0]          memory_address,
  input  logic [XLEN-1:0]          memory_data,
  input  logic [ROB_TAG_WIDTH-1:0] memory_rob_tag,
  input  logic                     kill_mem_req,
  input  logic                     flush,
  output logic                     load_succeeded,
  output logic [ROB_TAG_WIDTH-1:0] load_succeeded_rob_tag,
  output logic [XLEN-1:0]          load_data,
  output logic                     store_succeeded,
  output logic [ROB_TAG_WIDTH-1:0] store_succeeded_rob_tag
);

  localparam int IDX_W = $clog2(DEPTH);

  mem_req_t         accept_req;
  mem_req_t         final_req;
  logic [IDX_W-1:0] final_index;
  logic [XLEN-1:0]  mem [DEPTH];

  // Build the stage-0 record; a killed request enters as an empty slot.
  always_comb begin
    accept_req         = '0;
    accept_req.valid   = fire_memory_op && !kill_mem_req;
    accept_req.op      = mem_op_t'(memory_op_type);
    accept_req.index   = LSU_INDEX_WIDTH'(memory_address[2 +: IDX_W]);
    accept_req.data    = LSU_XLEN'(memory_data);
    accept_req.rob_tag = LSU_ROB_TAG_WIDTH'(memory_rob_tag);
  end

  mem_req_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .in_req  (accept_req),
    .out_req (final_req)
  );

  assign final_index = final_req.index[IDX_W-1:0];

  // Decode the final stage into response strobes, tags and load data.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    load_succeeded          = 1'b0;
    load_succeeded_rob_tag  = '0;
    load_data               = '0;
    store_succeeded         = 1'b0;
    store_succeeded_rob_tag = '0;
    if (final_req.valid) begin
      if (final_req.op == MEM_LOAD) begin
        load_succeeded         = 1'b1;
        load_succeeded_rob_tag = ROB_TAG_WIDTH'(final_req.rob_tag);
        load_data              = mem[final_index];
      end else begin
        store_succeeded         = 1'b1;
        store_succeeded_rob_tag = ROB_TAG_WIDTH'(final_req.rob_tag);
      end
    end
  end

  // Commit a final-stage store at the end of its response cycle.
  // NOTE: the array has no reset; its contents survive reset and only the
  // pipeline valids are cleared, which keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (store_succeeded) mem[final_index] <= XLEN'(final_req.data);
  end

  // Address bits outside the word index and spare index bits are unused.
  logic unused_bits;
  assign unused_bits = ^{memory_address, final_req.index};

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder (LATENCY=2, DEPTH=16): expected
// responses are queued when stimulus is driven and checked when strobes fire.
module tb_data_memory_responder;

  localparam int XLEN    = 32;
  localparam int TW      = 32;
  localparam int DEPTH   = 16;
  localparam int LATENCY = 2;

  logic            clk;
  logic            reset;
  logic            fire_memory_op;
  logic            memory_op_type;
  logic [XLEN-1:0] memory_address;
  logic [XLEN-1:0] memory_data;
  logic [TW-1:0]   memory_rob_tag;
  logic            kill_mem_req;
  logic            flush;
  logic            load_succeeded;
  logic [TW-1:0]   load_succeeded_rob_tag;
  logic [XLEN-1:0] load_data;
  logic            store_succeeded;
  logic [TW-1:0]   store_succeeded_rob_tag;

  data_memory_responder #(
    .XLEN          (XLEN),
    .ROB_TAG_WIDTH (TW),
    .DEPTH         (DEPTH),
    .LATENCY       (LATENCY)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .fire_memory_op          (fire_memory_op),
    .memory_op_type          (memory_op_type),
    .memory_address          (memory_address),
    .memory_data             (memory_data),
    .memory_rob_tag          (memory_rob_tag),
    .kill_mem_req            (kill_mem_req),
    .flush                   (flush),
    .load_succeeded          (load_succeeded),
    .load_succeeded_rob_tag  (load_succeeded_rob_tag),
    .load_data               (load_data),
    .store_succeeded         (store_succeeded),
    .store_succeeded_rob_tag (store_succeeded_rob_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_store;
    logic [31:0] tag;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] ref_mem [DEPTH];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and drop one-shot inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    fire_memory_op = 1'b0;
    kill_mem_req   = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Present one request for a cycle; queue its response if one is expected.
  task automatic issue(input bit is_store, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] tag, input bit kill_it, input bit flush_it,
                       input bit expect_resp);
    exp_t       e;
    logic [3:0] idx;
    fire_memory_op = 1'b1;
    memory_op_type = is_store;
    memory_address = addr;
    memory_data    = data;
    memory_rob_tag = tag;
    kill_mem_req   = kill_it;
    flush          = flush_it;
    idx            = addr[5:2];
    if (expect_resp) begin
      e.is_store = is_store;
      e.tag      = tag;
      e.due      = cyc + LATENCY;
      if (is_store) begin
        e.data       = '0;
        ref_mem[idx] = data;
      end else begin
        e.data = ref_mem[idx];
      end
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_load_strobe"}, load_succeeded, 0);
    check({name, "_store_strobe"}, store_succeeded, 0);
    check({name, "_load_tag"}, load_succeeded_rob_tag, 0);
    check({name, "_store_tag"}, store_succeeded_rob_tag, 0);
    check({name, "_load_data"}, load_data, 0);
  endtask

  // Response monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (load_succeeded || store_succeeded) begin
        check("single_strobe", load_succeeded & store_succeeded, 0);
        if (sb.size() == 0) begin
          check("response_was_expected", 64'(sb.size() != 0), 1);
        end else begin
          e = sb.pop_front();
          check("resp_kind", store_succeeded, e.is_store);
          check("resp_cycle", cyc, e.due);
          if (e.is_store) begin
            check("store_tag", store_succeeded_rob_tag, e.tag);
          end else begin
            check("load_tag", load_succeeded_rob_tag, e.tag);
            check("load_data", load_data, e.data);
          end
        end
      end else begin
        check("idle_outputs_zero",
              64'(load_succeeded_rob_tag | store_succeeded_rob_tag | load_data), 0);
      end
    end
  end

  initial begin
    reset          = 1'b0;
    fire_memory_op = 1'b0;
    memory_op_type = 1'b0;
    memory_address = '0;
    memory_data    = '0;
    memory_rob_tag = '0;
    kill_mem_req   = 1'b0;
    flush          = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // Store then load of the same word, back to back.
    issue(1'b1, 32'h8, 32'hDEAD_BEEF, 32'd5, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 32'h8, 32'h0,         32'd6, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Killed load leaves nothing; kill without fire is ignored.
    issue(1'b0, 32'h8, 32'h0, 32'd3, 1'b1, 1'b0, 1'b0);
    kill_mem_req = 1'b1;
    tick();
    idle(4);

    // Aliasing of upper address bits and ignored byte offset.
    issue(1'b1, 32'h4,  32'h1111_1111, 32'd7, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 32'h44, 32'h0,         32'd8, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 32'h7,  32'h0,         32'd9, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Flush: final-stage load survives, newly accepted load is squashed,
    // a store accepted under flush commits, a load in stage 0 is squashed.
    issue(1'b0, 32'h8, 32'h0,         32'd1,  1'b0, 1'b0, 1'b1);
    idle(1);
    issue(1'b0, 32'h8, 32'h0,         32'd2,  1'b0, 1'b1, 1'b0);
    issue(1'b1, 32'hC, 32'hCAFE_F00D, 32'd4,  1'b0, 1'b1, 1'b1);
    issue(1'b0, 32'hC, 32'h0,         32'd20, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    idle(4);

    // Full throughput: four stores then four loads back to back.
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), 32'(10 + i), 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 32'h10 + 32'(4 * i), 32'h0, 32'(14 + i), 1'b0, 1'b0, 1'b1);
    end
    idle(3);

    // Reset with a store (final stage) and a load in flight: both are lost.
    issue(1'b1, 32'h8,  32'h0BAD_F00D, 32'd30, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 32'h10, 32'h0,         32'd31, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("in_reset");
    @(negedge clk);
    check("in_reset_load_strobe_2", load_succeeded, 0);
    check("in_reset_store_strobe_2", store_succeeded, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");
    tick();
    issue(1'b0, 32'h8,  32'h0,         32'd32, 1'b0, 1'b0, 1'b1);
    issue(1'b1, 32'h20, 32'h5A5A_A5A5, 32'd33, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 32'h20, 32'h0,         32'd34, 1'b0, 1'b0, 1'b1);
    idle(4);

    // Bounded drain of anything still outstanding.
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Responder end of the LSU memory-request interface: accepts the single request per cycle issued by the load/store unit (fire/op type/address/data plus ROB tag), honours the same-cycle kill, and services it against a word-addressed data memory after a fixed pipeline latency. It returns `load_succeeded`/`store_succeeded` with the originating ROB tag, and load data, so the LDQ/STQ can retire entries. It sits between the LSU and the CDB/ROB side of the out-of-order core and stands in for the L1 data cache.

## Interface
- `XLEN`, 32, data/address width
- `ROB_TAG_WIDTH`, 32, ROB tag width
- `DEPTH`, 1024, memory words; power of two, ≥ 2
- `LATENCY`, 2, cycles from accept to response; ≥ 1
- `clk` in 1, single clock, rising edge
- `reset` in 1, asynchronous, active-low
- `fire_memory_op` in 1, request valid this cycle
- `memory_op_type` in 1, 0 = load, 1 = store
- `memory_address` in XLEN, byte address
- `memory_data` in XLEN, store data
- `memory_rob_tag` in ROB_TAG_WIDTH, ROB tag of the request
- `kill_mem_req` in 1, cancels the request presented this same cycle
- `flush` in 1, squashes all in-flight loads
- `load_succeeded` out 1, load response strobe
- `load_succeeded_rob_tag` out ROB_TAG_WIDTH, tag of the completing load
- `load_data` out XLEN, loaded word
- `store_succeeded` out 1, store response strobe
- `store_succeeded_rob_tag` out ROB_TAG_WIDTH, tag of the completing store

## Operation
- Accept: a request is accepted at the edge where `fire_memory_op && !kill_mem_req`. A killed request leaves no state. No backpressure; one accept per cycle.
- Word index = `memory_address[2 +: $clog2(DEPTH)]`. Bits [1:0] and bits above the index are ignored (aliasing, no fault). Word-only access, no byte enables.
- Request pipeline: `LATENCY` stages holding {valid, op, index, data, tag}, shifted every cycle; stage 0 is loaded at accept.
- Final stage, load: `load_succeeded`=1, tag and `load_data` = mem[index], read combinationally in that cycle.
- Final stage, store: `store_succeeded`=1, tag; mem[index] written at the end of that cycle.
- Ordering: in-order, single write point, so a load observes every store accepted before it. Load and store never respond in the same cycle.
- `flush`: at that edge, clears valid on every in-flight load, including one being accepted that cycle. Stores are committed and are never squashed. A load in the final stage during a `flush` cycle still responds in that cycle.
- Memory contents are not reset. Reset clears all pipeline valids.

## Timing
- Accept at edge T → response strobe high for exactly one cycle, T+LATENCY-1 to T+LATENCY (the cycle following edge T+LATENCY-1). At LATENCY=1 the response is the cycle right after accept.
- Back-to-back accepts → back-to-back responses; full throughput.
- Outputs are registered-stage-derived. `load_data` is a combinational array read of the final-stage index.
- Reset values: `load_succeeded`=0, `store_succeeded`=0. Tags and `load_data` are don't-care while their strobe is 0, but are driven to 0 when no response is present.
- Reset asserted mid-operation discards all in-flight requests with no responses. A store that has not yet reached its write cycle is lost.
- `kill_mem_req` without `fire_memory_op` is ignored. `flush` together with a store accept: the store is kept.

## Structure
- Shared package `lsu_pkg`: `mem_op_t` enum (`MEM_LOAD`=0, `MEM_STORE`=1) and the `mem_req_t` packed struct {valid, op, index, data, rob_tag}, parameterised via package-level widths used by the LSU.
- Sub-module `mem_req_pipe`: LATENCY-deep shift register of `mem_req_t` with per-stage load-flush. The top holds the array and response decode.

## Test plan
(LATENCY=2, DEPTH=16)
- Store addr 0x8, data 0xDEADBEEF, tag 5, then load addr 0x8, tag 6 next cycle → `store_succeeded` tag 5 two cycles after its accept, then `load_succeeded` tag 6 with `load_data`=0xDEADBEEF one cycle later.
- Load with `kill_mem_req`=1 same cycle, tag 3 → no `load_succeeded` in the following 4 cycles.
- Store 0x11111111 to addr 0x4, then loads of addr 0x44 and 0x7 → both return 0x11111111 (aliasing plus low-bit ignore).
- Two loads in flight (tags 1, 2), `flush` asserted the cycle the second is accepted → tag 1 responds, tag 2 never responds. A store accepted during the flush still gets `store_succeeded`.
- Four back-to-back stores (tags 10–13) → `store_succeeded` on four consecutive cycles in tag order.
- `reset` low with a store and a load in flight → no strobes, all strobes 0 during and after reset, and a new request after release completes normally.
